// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between I-cache line refills and data-side bursts (MEM_ARB_RR_EN selects round-robin, else fixed data priority).
// Latency: command/grant registered one cycle after the request is seen in IDLE; beats forwarded combinationally; done one cycle after the last beat.
// Backpressure: memory paces the burst via mem_ack_i, mem_rvalid_i and mem_wready_i; requesters hold their request until done, and the grant stays up until then.
module mem_arbiter #(
  parameter int BEATS  = 8,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_beat_valid_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_beat_valid_o,
  output logic              dc_wbeat_ready_o,
  output logic              dc_done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_wready_i,
  output logic [DATA_W-1:0] mem_wdata_o
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              owner_dc_q, owner_dc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pick_dc;
  logic              beat;
  logic              busy;
  logic              rd_xfer;
  logic              wr_xfer;

`ifdef MEM_ARB_RR_EN
  logic prefer_dc_q, prefer_dc_d;

  // Round-robin: on a tie the side not served last wins; pointer moves when a burst completes
  always_comb begin
    pick_dc     = dc_req_i & (~ic_req_i | prefer_dc_q);
    prefer_dc_d = prefer_dc_q;
    if (state_q == ST_DONE) prefer_dc_d = ~owner_dc_q;
  end

  // Pointer resets to favour the data side
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) prefer_dc_q <= 1'b1;
    else            prefer_dc_q <= prefer_dc_d;
  end
`else
  // Fixed priority: the data side wins every tie
  always_comb pick_dc = dc_req_i;
`endif

  // A beat counts only in XFER, on the handshake matching the burst direction
  always_comb beat = (state_q == ST_XFER) & (we_q ? mem_wready_i : mem_rvalid_i);

  // Burst sequencer: arbitrate in IDLE, issue command, count beats, pulse done
  always_comb begin
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ic_req_i | dc_req_i) begin
          owner_dc_d = pick_dc;
          we_d       = pick_dc & dc_we_i;
          addr_d     = (pick_dc ? dc_addr_i : ic_addr_i) & LINE_MASK;
          cnt_d      = '0;
          state_d    = ST_CMD;
        end
      end
      ST_CMD: begin
        if (mem_ack_i) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state; async reset abandons any burst in flight
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      owner_dc_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs decoded from state; data paths are gated so idle/reset outputs read as zero
  always_comb begin
    busy             = (state_q != ST_IDLE);
    rd_xfer          = (state_q == ST_XFER) & ~we_q;
    wr_xfer          = (state_q == ST_XFER) & we_q;
    ic_gnt_o         = busy & ~owner_dc_q;
    dc_gnt_o         = busy & owner_dc_q;
    ic_beat_valid_o  = rd_xfer & mem_rvalid_i & ~owner_dc_q;
    dc_beat_valid_o  = rd_xfer & mem_rvalid_i & owner_dc_q;
    dc_wbeat_ready_o = wr_xfer & mem_wready_i;
    ic_done_o        = (state_q == ST_DONE) & ~owner_dc_q;
    dc_done_o        = (state_q == ST_DONE) & owner_dc_q;
    rdata_o          = rd_xfer ? mem_rdata_i : '0;
    mem_wdata_o      = wr_xfer ? dc_wdata_i : '0;
    mem_req_o        = (state_q == ST_CMD);
    mem_we_o         = (state_q == ST_CMD) & we_q;
    mem_addr_o       = (state_q == ST_CMD) ? addr_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized burst stimulus checked against a transaction-level model of the arbiter.
// Drives inputs 1 time unit after the rising edge, samples outputs on the falling edge.
// Model tracks who was served last, expected line address and beat-by-beat forwarding.
module tb_mem_arbiter;
  localparam int BEATS      = 8;
  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = BEATS * DATA_W / 8;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              ic_req_i, dc_req_i, dc_we_i;
  logic [ADDR_W-1:0] ic_addr_i, dc_addr_i;
  logic [DATA_W-1:0] dc_wdata_i, mem_rdata_i;
  logic              ic_gnt_o, ic_beat_valid_o, ic_done_o;
  logic              dc_gnt_o, dc_beat_valid_o, dc_wbeat_ready_o, dc_done_o;
  logic [DATA_W-1:0] rdata_o, mem_wdata_o;
  logic              mem_req_o, mem_we_o, mem_ack_i, mem_rvalid_i, mem_wready_i;
  logic [ADDR_W-1:0] mem_addr_o;

  mem_arbiter #(.BEATS(BEATS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
    .ic_beat_valid_o(ic_beat_valid_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_gnt_o(dc_gnt_o), .dc_beat_valid_o(dc_beat_valid_o),
    .dc_wbeat_ready_o(dc_wbeat_ready_o), .dc_done_o(dc_done_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_wready_i(mem_wready_i), .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  // After reset the data side is favoured, i.e. as if the I-cache had been served last
  bit model_last_ic = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit model_pick_dc(input bit ic, input bit dc);
    if (ic && dc) begin
`ifdef MEM_ARB_RR_EN
      return model_last_ic;
`else
      return 1'b1;
`endif
    end
    return dc;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {ic_gnt_o, ic_beat_valid_o, ic_done_o, dc_gnt_o, dc_beat_valid_o,
                            dc_wbeat_ready_o, dc_done_o, mem_req_o, mem_we_o}, 0);
    check_eq({tag, "_rdata"}, rdata_o, 0);
    check_eq({tag, "_wdata"}, mem_wdata_o, 0);
    check_eq({tag, "_addr"}, mem_addr_o, 0);
  endtask

  task automatic do_reset();
    ic_req_i = 0; dc_req_i = 0; dc_we_i = 0; mem_ack_i = 0;
    mem_rvalid_i = 1; mem_wready_i = 1;
    mem_rdata_i = 64'hDEAD_BEEF_0BAD_F00D; dc_wdata_i = 64'hA5A5_5A5A_1234_5678;
    ic_addr_i = 32'h0000_1234; dc_addr_i = 32'h0000_5678;
    reset_n_i = 0;
    #1;
    check_all_zero("rst");
    step();
    step();
    reset_n_i = 1;
    model_last_ic = 1'b1;
    mem_rvalid_i = 0; mem_wready_i = 0;
  endtask

  task automatic go_idle(input int n);
    ic_req_i = 0; dc_req_i = 0; mem_rvalid_i = 0; mem_wready_i = 0; mem_ack_i = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check_eq("idle_req", mem_req_o, 0);
      check_eq("idle_gnt", {ic_gnt_o, dc_gnt_o}, 0);
      check_eq("idle_done", {ic_done_o, dc_done_o}, 0);
      step();
    end
  endtask

  // One burst starting in an IDLE cycle. pat: 0 random pacing, 1 alternating, 2 every cycle.
  // drop_at: release requests once that many beats are done. rst_at: async reset after that many beats.
  task automatic burst(input bit ic, input bit dc, input bit we,
                       input logic [31:0] ia, input logic [31:0] da,
                       input int ack_dly, input int pat, input int drop_at, input int rst_at);
    bit          odc;
    bit          v;
    logic [31:0] exp_addr;
    logic [63:0] d, w;
    int          beats;
    odc      = model_pick_dc(ic, dc);
    exp_addr = odc ? da : ia;
    exp_addr = exp_addr - (exp_addr % LINE_BYTES);

    ic_req_i = ic; dc_req_i = dc; dc_we_i = we; ic_addr_i = ia; dc_addr_i = da;
    mem_ack_i = 0; mem_rvalid_i = 1; mem_wready_i = 1; mem_rdata_i = {$urandom, $urandom};
    @(negedge clk_i);
    check_eq("idle_req", mem_req_o, 0);
    check_eq("idle_gnt", {ic_gnt_o, dc_gnt_o}, 0);
    check_eq("idle_done", {ic_done_o, dc_done_o}, 0);
    check_eq("idle_stray", {ic_beat_valid_o, dc_beat_valid_o, dc_wbeat_ready_o}, 0);
    step();

    for (int k = 0; k <= ack_dly; k++) begin
      mem_ack_i    = (k == ack_dly);
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_wready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      check_eq("cmd_req", mem_req_o, 1);
      check_eq("cmd_gnt", {ic_gnt_o, dc_gnt_o}, {!odc, odc});
      check_eq("cmd_addr", mem_addr_o, exp_addr);
      check_eq("cmd_we", mem_we_o, odc & we);
      check_eq("cmd_stray", {ic_beat_valid_o, dc_beat_valid_o, dc_wbeat_ready_o}, 0);
      step();
    end

    mem_ack_i = 0;
    beats = 0;
    for (int cyc = 0; beats < BEATS && cyc < 4 * BEATS + 8; cyc++) begin
      case (pat)
        1:       v = (cyc % 2 == 0);
        2:       v = 1'b1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = {$urandom, $urandom};
      w = {$urandom, $urandom};
      if (pat != 0) d = 64'(beats + 1) * 64'h11;
      mem_rvalid_i = v; mem_wready_i = v; mem_rdata_i = d; dc_wdata_i = w;
      if (drop_at != 0 && beats == drop_at) begin
        ic_req_i = 0; dc_req_i = 0;
      end
      if (rst_at != 0 && beats == rst_at) begin
        mem_rvalid_i = 1; mem_wready_i = 1;
        #2 reset_n_i = 0;
        #1;
        check_all_zero("mid_rst");
        ic_req_i = 0; dc_req_i = 0;
        for (int i = 0; i < 2; i++) begin
          @(negedge clk_i);
          check_eq("mid_rst_done", {ic_done_o, dc_done_o}, 0);
          step();
        end
        reset_n_i = 1;
        mem_rvalid_i = 0; mem_wready_i = 0;
        model_last_ic = 1'b1;
        return;
      end
      @(negedge clk_i);
      check_eq("x_gnt", {ic_gnt_o, dc_gnt_o}, {!odc, odc});
      check_eq("x_done", {ic_done_o, dc_done_o}, 0);
      check_eq("x_req", mem_req_o, 0);
      if (odc && we) begin
        check_eq("x_wrdy", dc_wbeat_ready_o, v);
        check_eq("x_wdata", mem_wdata_o, w);
        check_eq("x_bv_wr", {ic_beat_valid_o, dc_beat_valid_o}, 0);
      end else begin
        check_eq("x_bv", {ic_beat_valid_o, dc_beat_valid_o}, {v & !odc, v & odc});
        if (v) check_eq("x_rdata", rdata_o, d);
        check_eq("x_wrdy_rd", dc_wbeat_ready_o, 0);
      end
      if (v) beats++;
      step();
    end

    mem_rvalid_i = 1'($urandom_range(0, 1));
    mem_wready_i = 0;
    @(negedge clk_i);
    check_eq("done", {ic_done_o, dc_done_o}, {!odc, odc});
    check_eq("done_gnt", {ic_gnt_o, dc_gnt_o}, {!odc, odc});
    check_eq("done_req", mem_req_o, 0);
    check_eq("done_stray", {ic_beat_valid_o, dc_beat_valid_o}, 0);
    model_last_ic = !odc;
    step();
  endtask

  initial begin
    bit ic, dc;
    do_reset();

    // I-cache refill: ack on the second command cycle, beats 0x11..0x88 back to back
    burst(1, 0, 0, 32'h0000_1234, 32'h0, 1, 2, 0, 0);
    go_idle(2);
    // Data write-back with wready alternating 1,0,1...
    burst(0, 1, 1, 32'h0, 32'h0000_ABCD, 0, 1, 0, 0);
    go_idle(1);
    // Data refill read with random pacing
    burst(0, 1, 0, 32'h0, $urandom, 2, 0, 0, 0);
    go_idle(1);

    // Three back-to-back simultaneous bursts from a fresh reset
    do_reset();
    for (int i = 0; i < 3; i++) burst(1, 1, 0, $urandom, $urandom, 0, 2, 0, 0);
    go_idle(2);

    // I-cache drops its request after beat 3; burst still completes, nothing new starts
    burst(1, 0, 0, 32'h0000_4040, 32'h0, 0, 2, 3, 0);
    go_idle(3);

    // Async reset after beat 5, then a fresh refill must count all beats from zero
    burst(1, 0, 0, 32'h0000_2000, 32'h0, 0, 2, 0, 5);
    burst(1, 0, 0, 32'h0000_2010, 32'h0, 0, 2, 0, 0);
    go_idle(1);

    // Randomized mix of requesters, directions, ack delays and pacing
    for (int n = 0; n < 24; n++) begin
      ic = 1'($urandom_range(0, 1));
      dc = 1'($urandom_range(0, 1));
      if (!ic && !dc) ic = 1'b1;
      burst(ic, dc, 1'($urandom_range(0, 1)), $urandom, $urandom,
            $urandom_range(0, 3), 0, 0, 0);
      if ($urandom_range(0, 1) == 1) go_idle($urandom_range(1, 2));
    end
    go_idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
